// File: rtl/acelp_mem_arbiter_if.sv
// Bus bundle between the ACELP requester FSMs, the test port and the scratch-memory arbiter.
// master = requesters/test port side, slave = arbiter side.
interface acelp_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
);
    logic                       testMode;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         lock;
    logic [NUM_REQ*ADDR_W-1:0]  reqReadAddr;
    logic [NUM_REQ*ADDR_W-1:0]  reqWriteAddr;
    logic [NUM_REQ*DATA_W-1:0]  reqWriteData;
    logic [NUM_REQ-1:0]         reqWriteEn;
    logic [ADDR_W-1:0]          testReadAddr;
    logic [ADDR_W-1:0]          testWriteAddr;
    logic [DATA_W-1:0]          testMemOut;
    logic                       testMemWriteEn;
    logic [NUM_REQ-1:0]         grant;
    logic [ADDR_W-1:0]          memReadAddr;
    logic [ADDR_W-1:0]          memWriteAddr;
    logic [DATA_W-1:0]          memWriteData;
    logic                       memWriteEn;
    logic                       busy;

    modport master (
        output testMode, req, lock, reqReadAddr, reqWriteAddr, reqWriteData, reqWriteEn,
        output testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        input  grant, memReadAddr, memWriteAddr, memWriteData, memWriteEn, busy
    );

    modport slave (
        input  testMode, req, lock, reqReadAddr, reqWriteAddr, reqWriteData, reqWriteEn,
        input  testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        output grant, memReadAddr, memWriteAddr, memWriteData, memWriteEn, busy
    );
endinterface

// File: rtl/acelp_mem_arbiter.sv
// Round-robin arbiter giving one ACELP FSM at a time ownership of the shared scratch memory.
// A bounded hold counter lets a waiting requester pre-empt an unlocked owner; the test port overrides everything.
module acelp_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    acelp_mem_arbiter_if.slave   bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   win_idx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               busy;
    logic               win_found;
    logic               owner_req;
    logic               owner_lock;
    logic               others_req;
    logic               cnt_sat;

    logic [ADDR_W-1:0]  mem_ra;
    logic [ADDR_W-1:0]  mem_wa;
    logic [DATA_W-1:0]  mem_wd;
    logic               mem_we;

    // Owner attributes only look at the granted bit, so lock of non-owners is ignored.
    assign owner_req  = |(bus.req & grant);
    assign owner_lock = |(bus.lock & grant);
    assign others_req = |(bus.req & ~grant);
    assign cnt_sat    = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            busy  <= |grant_nxt;
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && bus.req[(int'(ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = OWN;
            OWN:     if (!owner_req || (cnt_sat && !owner_lock && others_req)) state_nxt = HANDOFF;
            HANDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.testMode) state_nxt = IDLE;
    end

    always_comb begin
        grant_nxt = '0;
        ptr_nxt   = ptr;
        cnt_nxt   = '0;
        if (state_nxt == OWN) begin
            if (state == IDLE) begin
                grant_nxt[win_idx] = 1'b1;
                ptr_nxt            = win_idx;
            end else begin
                grant_nxt = grant;
                cnt_nxt   = cnt_sat ? cnt : cnt + CNT_W'(1);
            end
        end
    end

    // Memory mux follows the registered grant; the test port wins whenever testMode is high.
    always_comb begin
        mem_ra = '0;
        mem_wa = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mem_ra = bus.reqReadAddr[i*ADDR_W +: ADDR_W];
                mem_wa = bus.reqWriteAddr[i*ADDR_W +: ADDR_W];
                mem_wd = bus.reqWriteData[i*DATA_W +: DATA_W];
                mem_we = bus.reqWriteEn[i];
            end
        end
        if (bus.testMode) begin
            mem_ra = bus.testReadAddr;
            mem_wa = bus.testWriteAddr;
            mem_wd = bus.testMemOut;
            mem_we = bus.testMemWriteEn;
        end
    end

    assign bus.grant        = grant;
    assign bus.busy         = busy;
    assign bus.memReadAddr  = mem_ra;
    assign bus.memWriteAddr = mem_wa;
    assign bus.memWriteData = mem_wd;
    assign bus.memWriteEn   = mem_we;
    assign state_dbg        = state;
endmodule

// File: tb/tb_acelp_mem_arbiter.sv
// Directed bench for acelp_mem_arbiter: reset, first grant, round robin, pre-emption, lock,
// test-port override, asynchronous reset and non-owner write-enable isolation.
module tb_acelp_mem_arbiter;
    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_dbg;
    int         n_vec = 0;
    int         n_err = 0;

    acelp_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    acelp_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Requester i reads 0x100+i, writes 0x200+i with data 0xA0000000+i unless a test overrides it.
    task automatic clear_inputs();
        bus.testMode       = 1'b0;
        bus.req            = '0;
        bus.lock           = '0;
        bus.reqWriteEn     = '0;
        bus.testReadAddr   = '0;
        bus.testWriteAddr  = '0;
        bus.testMemOut     = '0;
        bus.testMemWriteEn = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.reqReadAddr[i*AW +: AW]  = AW'(32'h100 + i);
            bus.reqWriteAddr[i*AW +: AW] = AW'(32'h200 + i);
            bus.reqWriteData[i*DW +: DW] = 32'hA000_0000 + i;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_vec++; if (bus.memWriteEn !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", bus.memWriteEn); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        n_vec++; if (bus.memWriteAddr !== 12'h000) begin n_err++; $display("FAIL reset_wa got %h exp 000", bus.memWriteAddr); end
        reset = 1'b1;
    endtask

    task automatic test_first_grant();
        do_reset();
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL fg_idle got %b exp 0000", bus.grant); end
        bus.req = 4'b0001;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL fg_grant got %b exp 0001", bus.grant); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fg_busy got %b exp 1", bus.busy); end
        n_vec++; if (bus.memWriteAddr !== 12'h200) begin n_err++; $display("FAIL fg_wa got %h exp 200", bus.memWriteAddr); end
        n_vec++; if (bus.memReadAddr !== 12'h100) begin n_err++; $display("FAIL fg_ra got %h exp 100", bus.memReadAddr); end
        n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL fg_state got %0d exp 1", state_dbg); end
        bus.req = 4'b0000;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000 || state_dbg !== 2'd2) begin n_err++; $display("FAIL fg_handoff got %b/%0d exp 0000/2", bus.grant, state_dbg); end
        @(negedge clk);
        n_vec++; if (state_dbg !== 2'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL fg_back_idle got %0d/%b exp 0/0", state_dbg, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = 4'b0001 << (n % 4);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_vec++; if (bus.grant !== exp) begin n_err++; $display("FAIL rr_grant n=%0d c=%0d got %b exp %b", n, c, bus.grant, exp); end
            end
            bus.req[n % 4] = 1'b0;
            @(negedge clk);
            n_vec++; if (bus.grant !== 4'b0000 || state_dbg !== 2'd2) begin n_err++; $display("FAIL rr_handoff n=%0d got %b/%0d exp 0000/2", n, bus.grant, state_dbg); end
            bus.req[n % 4] = 1'b1;
            @(negedge clk);
            n_vec++; if (bus.grant !== 4'b0000 || state_dbg !== 2'd0) begin n_err++; $display("FAIL rr_idle n=%0d got %b/%0d exp 0000/0", n, bus.grant, state_dbg); end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < MH + 1; c++) begin
            @(negedge clk);
            n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL pe_hold c=%0d got %b exp 0001", c, bus.grant); end
        end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000 || state_dbg !== 2'd2) begin n_err++; $display("FAIL pe_handoff got %b/%0d exp 0000/2", bus.grant, state_dbg); end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000 || state_dbg !== 2'd0) begin n_err++; $display("FAIL pe_idle got %b/%0d exp 0000/0", bus.grant, state_dbg); end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL pe_next got %b exp 0010", bus.grant); end

        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL lock_hold c=%0d got %b exp 0001", c, bus.grant); end
        end
    endtask

    task automatic test_test_mode();
        do_reset();
        bus.req                      = 4'b0100;
        bus.reqWriteEn               = 4'b0100;
        bus.reqWriteAddr[2*AW +: AW] = 12'h123;
        bus.reqWriteData[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL tm_own got %b exp 0100", bus.grant); end
        n_vec++; if (bus.memWriteAddr !== 12'h123) begin n_err++; $display("FAIL tm_own_wa got %h exp 123", bus.memWriteAddr); end
        n_vec++; if (bus.memWriteData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tm_own_wd got %h exp deadbeef", bus.memWriteData); end
        n_vec++; if (bus.memWriteEn !== 1'b1) begin n_err++; $display("FAIL tm_own_we got %b exp 1", bus.memWriteEn); end
        bus.testMode       = 1'b1;
        bus.testWriteAddr  = 12'h3C3;
        bus.testReadAddr   = 12'h111;
        bus.testMemOut     = 32'h5A5A_1234;
        bus.testMemWriteEn = 1'b0;
        #1;
        n_vec++; if (bus.memWriteAddr !== 12'h3C3) begin n_err++; $display("FAIL tm_wa got %h exp 3c3", bus.memWriteAddr); end
        n_vec++; if (bus.memReadAddr !== 12'h111) begin n_err++; $display("FAIL tm_ra got %h exp 111", bus.memReadAddr); end
        n_vec++; if (bus.memWriteData !== 32'h5A5A_1234) begin n_err++; $display("FAIL tm_wd got %h exp 5a5a1234", bus.memWriteData); end
        n_vec++; if (bus.memWriteEn !== 1'b0) begin n_err++; $display("FAIL tm_we got %b exp 0", bus.memWriteEn); end
        n_vec++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL tm_same_cycle_grant got %b exp 0100", bus.grant); end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin n_err++; $display("FAIL tm_cleared got %b/%b exp 0000/0", bus.grant, bus.busy); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL tm_state got %0d exp 0", state_dbg); end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL tm_blocked got %b exp 0000", bus.grant); end
        bus.testMode = 1'b0;
        bus.req      = 4'b1100;
        #1;
        n_vec++; if (bus.memWriteEn !== 1'b0 || bus.memWriteAddr !== 12'h000) begin n_err++; $display("FAIL tm_no_owner got %b/%h exp 0/000", bus.memWriteEn, bus.memWriteAddr); end
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL tm_ptr_kept got %b exp 1000", bus.grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req        = 4'b0010;
        bus.reqWriteEn = 4'b0010;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0010 || bus.memWriteEn !== 1'b1) begin n_err++; $display("FAIL ar_own got %b/%b exp 0010/1", bus.grant, bus.memWriteEn); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL ar_grant got %b exp 0000", bus.grant); end
        n_vec++; if (bus.memWriteEn !== 1'b0) begin n_err++; $display("FAIL ar_we got %b exp 0", bus.memWriteEn); end
        n_vec++; if (bus.busy !== 1'b0 || state_dbg !== 2'd0) begin n_err++; $display("FAIL ar_state got %b/%0d exp 0/0", bus.busy, state_dbg); end
        @(negedge clk);
        reset          = 1'b1;
        bus.req        = 4'b0110;
        bus.reqWriteEn = 4'b0000;
        @(negedge clk);
        n_vec++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL ar_rearb got %b exp 0010", bus.grant); end
    endtask

    task automatic test_non_owner_we();
        do_reset();
        bus.req        = 4'b0011;
        bus.reqWriteEn = 4'b0010;
        for (int c = 0; c < MH + 2; c++) begin
            @(negedge clk);
            n_vec++; if (bus.memWriteEn !== 1'b0) begin n_err++; $display("FAIL nowe_we c=%0d got %b exp 0", c, bus.memWriteEn); end
            if (c <= MH) begin
                n_vec++; if (bus.grant !== 4'b0001 || bus.memWriteAddr !== 12'h200) begin n_err++; $display("FAIL nowe_owner c=%0d got %b/%h exp 0001/200", c, bus.grant, bus.memWriteAddr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_preempt();
        test_test_mode();
        test_async_reset();
        test_non_owner_we();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acelp_mem_arbiter.md
ACELP_MEM_ARBITER -- requirements
Module: acelp_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting FSMs sharing the scratch memory (2..8).
REQ-002 Parameter ADDR_W, default 12, scratch memory address width.
REQ-003 Parameter DATA_W, default 32, scratch memory data width.
REQ-004 Parameter MAX_HOLD, default 255, grant cycles before an unlocked owner can be pre-empted (1..65535).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 testMode  input  1  1 = test port owns memory; all grants forced to 0.
REQ-008 req  input  NUM_REQ  per-requester access request.
REQ-009 lock  input  NUM_REQ  per-requester no-pre-emption flag, sampled only for the current owner.
REQ-010 reqReadAddr  input  NUM_REQ*ADDR_W  requester i read address at bits [i*ADDR_W +: ADDR_W].
REQ-011 reqWriteAddr  input  NUM_REQ*ADDR_W  requester write addresses, same packing.
REQ-012 reqWriteData  input  NUM_REQ*DATA_W  requester write data, same packing.
REQ-013 reqWriteEn  input  NUM_REQ  requester write enables.
REQ-014 testReadAddr, testWriteAddr  input  ADDR_W each; testMemOut  input  DATA_W; testMemWriteEn  input  1  test port.
REQ-015 grant  output  NUM_REQ  registered one-hot (or zero) ownership vector.
REQ-016 memReadAddr, memWriteAddr  output  ADDR_W each; memWriteData  output  DATA_W; memWriteEn  output  1  to scratch memory.
REQ-017 busy  output  1  registered; 1 while any grant is held.

Function
REQ-018 FSM states IDLE, OWN, HANDOFF; reset state IDLE.
REQ-019 IDLE: if testMode=0 and any req bit set, select winner round-robin starting at index ptr+1 modulo NUM_REQ; next cycle grant = one-hot winner, state OWN; otherwise stay IDLE, grant = 0.
REQ-020 Grant latency: req rising in cycle t with arbiter in IDLE yields grant in cycle t+1.
REQ-021 ptr (round-robin pointer) updated to winner index on entry to OWN; reset value NUM_REQ-1 so requester 0 has first priority.
REQ-022 OWN: hold counter increments each cycle, saturating at MAX_HOLD; reset to 0 on entry to OWN.
REQ-023 OWN -> HANDOFF when owner req drops, or when counter = MAX_HOLD, owner lock = 0, and any other req bit is set.
REQ-024 HANDOFF: grant = 0, memWriteEn = 0 for exactly one cycle, then IDLE; pre-empted owner keeping req high competes normally in IDLE.
REQ-025 Owner with lock = 1 is never pre-empted; counter stays saturated.
REQ-026 Output mux (combinational from registered grant): owner's read address, write address, write data drive mem outputs; memWriteEn = owner reqWriteEn.
REQ-027 No owner and testMode=0: memReadAddr, memWriteAddr, memWriteData = 0, memWriteEn = 0.
REQ-028 testMode=1: mem outputs driven by test port combinationally in same cycle; grant cleared and state forced to IDLE on next edge regardless of state; ptr unchanged.
REQ-029 Simultaneous owner req drop and pre-emption condition: treated as one HANDOFF.
REQ-030 Requests from non-owners never affect mem outputs; non-owner reqWriteEn ignored.
REQ-031 busy = 1 exactly when grant != 0.

Reset
REQ-032 reset low asynchronously sets state IDLE, grant 0, busy 0, counter 0, ptr NUM_REQ-1; memWriteEn 0 unless testMode=1.
REQ-033 Reset assertion mid-OWN drops grant immediately without a HANDOFF cycle; first arbitration after release follows REQ-019.

Verification
REQ-034 Reset release, req=4'b0001 at cycle 2 -> grant=0001 at cycle 3, busy=1, memWriteAddr = req0 write address.
REQ-035 req=4'b1111 held, each owner drops req after 3 grant cycles -> grant order 0001,0010,0100,1000,0001 with one zero-grant HANDOFF cycle between each.
REQ-036 MAX_HOLD=4, owner 0 req held lock=0, req1 high -> grant 0001 for 5 cycles, HANDOFF 1 cycle, grant 0010; repeat with lock0=1 -> grant 0001 never released.
REQ-037 Owner 2 writing (reqWriteEn2=1, addr 0x123, data 0xDEADBEEF), testMode set -> same cycle memWriteAddr=testWriteAddr, memWriteData=testMemOut; next cycle grant=0.
REQ-038 reset pulsed low mid-OWN -> grant=0, memWriteEn=0 asynchronously; after release req=4'b0110 -> grant=0010.
REQ-039 Non-owner reqWriteEn=1 with owner reqWriteEn=0 -> memWriteEn=0 every cycle.
